// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Owns the architectural PC. Fetches one instruction at a time
//            over a req/gnt/rvalid memory handshake, holds it for
//            decode/execute until it retires, then commits the next PC
//            supplied by the PC-select mux. Misaligned targets and
//            fetch-response timeouts put the block into a sticky fault
//            state that only reset clears.
// Ports    :
//   clk          in   1   core clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   halt         in   1   stop fetching once the current instruction retires
//   imem_req     out  1   fetch request (REQ state only)
//   imem_addr    out  32  fetch address (= pc)
//   imem_gnt     in   1   request accepted this cycle
//   imem_rvalid  in   1   read data valid
//   imem_rdata   in   32  instruction word
//   instr_valid  out  1   instr/instr_pc hold a valid instruction
//   instr        out  32  captured instruction word
//   instr_pc     out  32  address of instr
//   instr_ready  in   1   execute retires instr this cycle
//   pc_next      in   32  next PC, sampled only at retire
//   pc           out  32  architectural PC
//   halted       out  1   in HALTED state
//   fault        out  1   sticky fault
//   fault_cause  out  2   00 none, 01 misaligned target, 10 fetch timeout
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0040_0000,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  // Counter value seen during the last permitted WAIT cycle, and the
  // saturation ceiling.
  localparam logic [CW-1:0] c_TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] c_TO_MAX  = CW'(TIMEOUT_CYCLES);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_REQ    = 3'd1;
  localparam logic [2:0] c_WAIT   = 3'd2;
  localparam logic [2:0] c_ISSUE  = 3'd3;
  localparam logic [2:0] c_HALTED = 3'd4;
  localparam logic [2:0] c_FAULT  = 3'd5;

  localparam logic [1:0] c_CAUSE_NONE     = 2'b00;
  localparam logic [1:0] c_CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] c_CAUSE_TIMEOUT  = 2'b10;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [31:0]   r_instr_pc;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cause;

  logic          w_capture;
  logic          w_retire;
  logic          w_clr_cnt;
  logic          w_inc_cnt;
  logic          w_set_cause;
  logic [1:0]    w_cause_nxt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic and datapath enables
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    w_clr_cnt   = 1'b0;
    w_inc_cnt   = 1'b0;
    w_set_cause = 1'b0;
    w_cause_nxt = c_CAUSE_NONE;

    case (r_state)
      c_IDLE: begin
        w_state_nxt = halt ? c_HALTED : c_REQ;
      end

      // halt is deliberately not looked at here: a request on the bus
      // must be allowed to complete.
      c_REQ: begin
        if (imem_gnt && imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = c_ISSUE;
        end else if (imem_gnt) begin
          w_clr_cnt   = 1'b1;
          w_state_nxt = c_WAIT;
        end
      end

      // A response in the final permitted cycle still wins over the timeout.
      c_WAIT: begin
        if (imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = c_ISSUE;
        end else begin
          w_inc_cnt = 1'b1;
          if (r_cnt >= c_TO_LAST) begin
            w_set_cause = 1'b1;
            w_cause_nxt = c_CAUSE_TIMEOUT;
            w_state_nxt = c_FAULT;
          end
        end
      end

      // The PC is committed even on a misaligned target so the offending
      // address is visible for debug.
      c_ISSUE: begin
        if (instr_ready) begin
          w_retire = 1'b1;
          if (pc_next[1:0] != 2'b00) begin
            w_set_cause = 1'b1;
            w_cause_nxt = c_CAUSE_MISALIGN;
            w_state_nxt = c_FAULT;
          end else if (halt) begin
            w_state_nxt = c_HALTED;
          end else begin
            w_state_nxt = c_REQ;
          end
        end
      end

      c_HALTED: begin
        if (!halt) begin
          w_state_nxt = c_REQ;
        end
      end

      c_FAULT: begin
        w_state_nxt = c_FAULT;
      end

      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (state only, no input-to-output paths)
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    case (r_state)
      c_REQ:    imem_req    = 1'b1;
      c_ISSUE:  instr_valid = 1'b1;
      c_HALTED: halted      = 1'b1;
      c_FAULT:  fault       = 1'b1;
      default:  ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_VECTOR;
      r_instr    <= 32'h0;
      r_instr_pc <= 32'h0;
      r_cnt      <= '0;
      r_cause    <= c_CAUSE_NONE;
    end else begin
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_retire) begin
        r_pc <= pc_next;
      end
      // Saturating timeout counter.
      if (w_clr_cnt) begin
        r_cnt <= '0;
      end else if (w_inc_cnt && (r_cnt != c_TO_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_set_cause) begin
        r_cause <= w_cause_nxt;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fault_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed self-checking bench for fetch_sequencer. Inputs are
//            driven 1 ns after each rising edge and outputs are checked at
//            the same point, so every check observes the state entered on
//            the preceding edge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam logic [31:0] c_RV = 32'h0040_0000;
  localparam int          c_TO = 15;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_cause;

  int n_checks;
  int n_errors;

  fetch_sequencer #(
    .RESET_VECTOR   (c_RV),
    .TIMEOUT_CYCLES (c_TO)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .pc_next     (pc_next),
    .pc          (pc),
    .halted      (halted),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    halt        = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    pc_next     = 32'h0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_req",      imem_req,    0);
    check("rst_ivalid",   instr_valid, 0);
    check("rst_instr",    instr,       0);
    check("rst_instr_pc", instr_pc,    0);
    check("rst_pc",       pc,          c_RV);
    check("rst_halted",   halted,      0);
    check("rst_fault",    fault,       0);
    check("rst_cause",    fault_cause, 0);

    rst_n = 1'b1;
    tick();                                   // IDLE -> REQ
    check("t1_req",  imem_req,  1);
    check("t1_addr", imem_addr, c_RV);

    // ---------------- back-to-back fetch, same-cycle gnt+rvalid ----------------
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    instr_ready = 1'b1; pc_next = 32'h0040_0004;
    tick();                                   // REQ -> ISSUE
    check("t1_ivalid",   instr_valid, 1);
    check("t1_instr",    instr,       32'h0000_0013);
    check("t1_instr_pc", instr_pc,    32'h0040_0000);
    check("t1_req_lo",   imem_req,    0);
    check("t1_pc_hold",  pc,          32'h0040_0000);
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    tick();                                   // ISSUE -> REQ (2 cycles total)
    check("t1_pc",       pc,          32'h0040_0004);
    check("t1_req2",     imem_req,    1);
    check("t1_addr2",    imem_addr,   32'h0040_0004);
    check("t1_ivalid_lo", instr_valid, 0);

    // ---------------- delayed response and execute stall ----------------
    instr_ready = 1'b0; imem_gnt = 1'b1;
    tick();                                   // REQ -> WAIT
    check("t2_wait_req", imem_req,    0);
    check("t2_wait_iv",  instr_valid, 0);
    imem_gnt = 1'b0;
    tick();
    tick();                                   // third WAIT cycle
    imem_rvalid = 1'b1; imem_rdata = 32'hAABB_CCDD;
    tick();                                   // WAIT -> ISSUE
    check("t2_ivalid",   instr_valid, 1);
    check("t2_instr",    instr,       32'hAABB_CCDD);
    check("t2_instr_pc", instr_pc,    32'h0040_0004);
    imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF; pc_next = 32'h0040_0008;
    for (int i = 0; i < 2; i++) begin
      tick();                                 // stalled: ready low
      check("t2_stall_iv",    instr_valid, 1);
      check("t2_stall_instr", instr,       32'hAABB_CCDD);
      check("t2_stall_pc",    pc,          32'h0040_0004);
    end
    instr_ready = 1'b1;
    tick();                                   // retire
    check("t2_pc",      pc,          32'h0040_0008);
    check("t2_iv_lo",   instr_valid, 0);
    check("t2_req",     imem_req,    1);

    // ---------------- taken branch, then misaligned target ----------------
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0063;
    pc_next = 32'h0040_0100;
    tick();                                   // ISSUE
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    tick();                                   // REQ at branch target
    check("t3_br_addr", imem_addr, 32'h0040_0100);
    check("t3_br_req",  imem_req,  1);
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0067;
    pc_next = 32'h0040_0102;
    tick();                                   // ISSUE
    check("t3_instr_pc", instr_pc, 32'h0040_0100);
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    tick();                                   // -> FAULT
    check("t3_fault",  fault,       1);
    check("t3_cause",  fault_cause, 2'b01);
    check("t3_pc",     pc,          32'h0040_0102);
    check("t3_req",    imem_req,    0);
    check("t3_iv",     instr_valid, 0);
    halt = 1'b1; imem_gnt = 1'b1; pc_next = 32'h0040_0200;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_req",   imem_req,    0);
      check("t3_hold_fault", fault,       1);
      check("t3_hold_cause", fault_cause, 2'b01);
      check("t3_hold_pc",    pc,          32'h0040_0102);
      check("t3_hold_halt",  halted,      0);
    end
    halt = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0;

    // ---------------- reset out of FAULT ----------------
    rst_n = 1'b0;
    tick();
    check("t6f_fault", fault,       0);
    check("t6f_cause", fault_cause, 0);
    check("t6f_pc",    pc,          c_RV);
    check("t6f_req",   imem_req,    0);
    rst_n = 1'b1;
    tick();                                   // IDLE -> REQ
    check("t6f_req2",  imem_req,    1);

    // ---------------- fetch timeout ----------------
    imem_gnt = 1'b1;
    tick();                                   // WAIT cycle 1
    imem_gnt = 1'b0;
    for (int i = 0; i < c_TO - 1; i++) tick(); // now in WAIT cycle 15
    check("t4_nofault_yet", fault, 0);
    tick();
    check("t4_fault", fault,       1);
    check("t4_cause", fault_cause, 2'b10);
    check("t4_req",   imem_req,    0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();                                   // REQ
    imem_gnt = 1'b1;
    tick();                                   // WAIT cycle 1
    imem_gnt = 1'b0;
    for (int i = 0; i < c_TO - 1; i++) tick(); // WAIT cycle 15
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5677;
    tick();                                   // response wins over timeout
    check("t4b_iv",    instr_valid, 1);
    check("t4b_fault", fault,       0);
    check("t4b_cause", fault_cause, 0);
    check("t4b_instr", instr,       32'h1234_5677);

    // ---------------- halt ----------------
    imem_rvalid = 1'b0; halt = 1'b1; instr_ready = 1'b1; pc_next = 32'h0040_0004;
    tick();                                   // ISSUE -> HALTED
    check("t5_halted", halted,      1);
    check("t5_req",    imem_req,    0);
    check("t5_iv",     instr_valid, 0);
    check("t5_pc",     pc,          32'h0040_0004);
    instr_ready = 1'b0; pc_next = 32'h0040_0300;
    tick();
    check("t5_still",  halted,      1);
    check("t5_req2",   imem_req,    0);
    halt = 1'b0;
    tick();                                   // HALTED -> REQ
    check("t5_unhalt", halted,      0);
    check("t5_req3",   imem_req,    1);
    check("t5_addr",   imem_addr,   32'h0040_0004);

    // ---------------- reset during WAIT, late response ignored ----------------
    imem_gnt = 1'b1;
    tick();                                   // WAIT
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    tick();                                   // IDLE
    check("t6w_pc",    pc,          c_RV);
    check("t6w_req",   imem_req,    0);
    check("t6w_iv",    instr_valid, 0);
    check("t6w_instr", instr,       0);
    check("t6w_fault", fault,       0);
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();                                   // IDLE -> REQ, rvalid ignored
    check("t6w_req2",   imem_req,    1);
    check("t6w_iv2",    instr_valid, 0);
    check("t6w_instr2", instr,       0);
    tick();                                   // rvalid without gnt: stay in REQ
    check("t6w_req3",   imem_req,    1);
    check("t6w_iv3",    instr_valid, 0);
    imem_rvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
